// File: rtl/sub_share_arb.sv
// Round-robin arbiter that time-shares one fixed-latency sub unit among
// NREQ requesters, with burst locking and tagged response steering.
module sub_share_arb #(
    parameter int NREQ      = 4,
    parameter int DW        = 3,
    parameter int SUB_LAT   = 2,
    parameter int MAX_BURST = 2
) (
    input  logic                 clk,
    input  logic                 reset_l,
    input  logic [NREQ-1:0]      req_l,
    input  logic [NREQ-1:0]      lock_l,
    input  logic [NREQ*DW-1:0]   req_data,
    input  logic                 sub_rdy,
    input  logic [DW-1:0]        sub_out,
    output logic [NREQ-1:0]      gnt_l,
    output logic [DW-1:0]        sub_in,
    output logic                 sub_vld,
    output logic [NREQ-1:0]      rsp_vld,
    output logic [DW-1:0]        rsp_data,
    output logic                 busy
);

    localparam int PW = $clog2(NREQ);
    localparam int BW = $clog2(MAX_BURST + 1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        GRANT  = 2'd1,
        LOCKED = 2'd2
    } state_t;

    // Increment a requester index, wrapping NREQ-1 back to 0.
    function automatic logic [PW-1:0] next_idx(input logic [PW-1:0] v);
        return (v == PW'(NREQ - 1)) ? '0 : v + PW'(1);
    endfunction

    state_t            state_q, state_d;
    logic [PW-1:0]     ptr_q, ptr_d;
    logic [PW-1:0]     owner_q, owner_d;
    logic [BW-1:0]     burst_q, burst_d;
    logic              arb_en_q;

    logic [NREQ-1:0]   req;
    logic [NREQ-1:0]   elig;
    logic [PW-1:0]     scan_ptr;
    logic [PW-1:0]     cand;
    logic              win_vld;
    logic [PW-1:0]     win;
    logic [DW-1:0]     req_arr [NREQ];
    logic [NREQ-1:0]   gnt_d;
    logic [NREQ-1:0]   rsp_hot;

    // Stage 0 is the issue cycle; stage SUB_LAT lines up with sub_out.
    logic [SUB_LAT:0]  pipe_vld;
    logic [PW-1:0]     pipe_tag [SUB_LAT+1];

    assign req     = ~req_l;
    assign sub_vld = pipe_vld[0];
    assign busy    = ~(&gnt_l) | (|pipe_vld) | (|rsp_vld);

    for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
        assign req_arr[gi] = req_data[gi*DW +: DW];
    end

    // Reset release is seen one edge late so the first decision lands on the second edge.
    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) arb_en_q <= 1'b0;
        else          arb_en_q <= 1'b1;
    end

    // Arbitration: honour an active lock first, otherwise round-robin from the pointer.
    always_comb begin
        // NOTE: every variable gets a default first so no path leaves a latch behind.
        state_d  = state_q;
        ptr_d    = ptr_q;
        owner_d  = owner_q;
        burst_d  = burst_q;
        win_vld  = 1'b0;
        win      = '0;
        scan_ptr = ptr_q;
        cand     = ptr_q;
        // The requester granted this cycle has not yet seen its grant, so mask it.
        elig     = req & gnt_l;
        if (arb_en_q && sub_rdy) begin
            if (state_q == LOCKED) begin
                if (req[owner_q] && !lock_l[owner_q] && burst_q < BW'(MAX_BURST)) begin
                    win_vld = 1'b1;
                    win     = owner_q;
                    burst_d = burst_q + BW'(1);
                end else begin
                    scan_ptr = next_idx(owner_q);
                    ptr_d    = scan_ptr;
                    burst_d  = '0;
                    state_d  = IDLE;
                end
            end
            if (!win_vld) begin
                cand = scan_ptr;
                for (int i = 0; i < NREQ; i++) begin
                    if (!win_vld && elig[cand]) begin
                        win_vld = 1'b1;
                        win     = cand;
                    end
                    cand = next_idx(cand);
                end
                if (win_vld) begin
                    ptr_d = next_idx(win);
                    if (!lock_l[win]) begin
                        state_d = LOCKED;
                        owner_d = win;
                        burst_d = BW'(1);
                    end else begin
                        state_d = GRANT;
                        burst_d = '0;
                    end
                end else begin
                    state_d = IDLE;
                end
            end
        end
    end

    // Arbiter state registers.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q <= IDLE;
            ptr_q   <= '0;
            owner_q <= '0;
            burst_q <= '0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            owner_q <= owner_d;
            burst_q <= burst_d;
        end
    end

    // Active-low one-hot grant for the winner.
    always_comb begin
        gnt_d = '1;
        if (win_vld) gnt_d[win] = 1'b0;
    end

    // One-hot strobe for the tag whose result is on sub_out.
    always_comb begin
        rsp_hot = '0;
        rsp_hot[pipe_tag[SUB_LAT]] = 1'b1;
    end

    // Issue, valid pipeline and response registers; reset flushes all in-flight work.
    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            gnt_l    <= '1;
            sub_in   <= '0;
            pipe_vld <= '0;
            rsp_vld  <= '0;
            rsp_data <= '0;
        end else begin
            gnt_l <= gnt_d;
            if (win_vld) sub_in <= req_arr[win];
            pipe_vld <= {pipe_vld[SUB_LAT-1:0], win_vld};
            if (pipe_vld[SUB_LAT]) begin
                rsp_vld  <= rsp_hot;
                rsp_data <= sub_out;
            end else begin
                rsp_vld  <= '0;
            end
        end
    end

    // Tag shift register travelling alongside pipe_vld.
    // NOTE: tags carry no reset; they are only ever read when the matching valid bit is set.
    always_ff @(posedge clk) begin
        pipe_tag[0] <= win;
        for (int k = 1; k <= SUB_LAT; k++) pipe_tag[k] <= pipe_tag[k-1];
    end

endmodule

// File: tb/tb_sub_share_arb.sv
// Self-checking bench for sub_share_arb: directed scenarios then random traffic,
// compared cycle by cycle against an integer-level arbitration model.
module tb_sub_share_arb;

    localparam int NREQ      = 4;
    localparam int DW        = 3;
    localparam int SUB_LAT   = 2;
    localparam int MAX_BURST = 2;
    localparam int MAXC      = 2048;

    logic                clk = 1'b0;
    logic                reset_l;
    logic [NREQ-1:0]     req_l;
    logic [NREQ-1:0]     lock_l;
    logic [NREQ*DW-1:0]  req_data;
    logic                sub_rdy;
    logic [DW-1:0]       sub_out;
    logic [NREQ-1:0]     gnt_l;
    logic [DW-1:0]       sub_in;
    logic                sub_vld;
    logic [NREQ-1:0]     rsp_vld;
    logic [DW-1:0]       rsp_data;
    logic                busy;

    always #5 clk = ~clk;

    sub_share_arb #(
        .NREQ(NREQ), .DW(DW), .SUB_LAT(SUB_LAT), .MAX_BURST(MAX_BURST)
    ) dut (
        .clk(clk), .reset_l(reset_l), .req_l(req_l), .lock_l(lock_l),
        .req_data(req_data), .sub_rdy(sub_rdy), .sub_out(sub_out),
        .gnt_l(gnt_l), .sub_in(sub_in), .sub_vld(sub_vld),
        .rsp_vld(rsp_vld), .rsp_data(rsp_data), .busy(busy)
    );

    int n_chk  = 0;
    int n_fail = 0;
    int cyc    = 0;

    // Expected grant (index or -1) and issued operand, per cycle.
    int           eg [MAXC];
    logic [DW-1:0] ed [MAXC];

    // Requester agents.
    bit            pend  [NREQ];
    bit            lockw [NREQ];
    bit            hold  [NREQ];
    logic [DW-1:0] data  [NREQ];

    bit rand_mode     = 1'b0;
    bit rdy_dir       = 1'b1;
    bit last_rst_high = 1'b0;

    // Reference arbitration state.
    int ptr   = 0;
    int owner = -1;
    int burst = 0;
    logic [DW-1:0] exp_rd = '0;

    // Behaviour of the shared unit as modelled by the bench.
    function automatic logic [DW-1:0] sub_fn(input logic [DW-1:0] x);
        return x + DW'(1);
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h at cycle %0d", tag, obs, exp, cyc);
        end
    endtask

    // Decide the grant for the next cycle from the current inputs.
    task automatic model_decide(input bit go, output int g);
        int cur;
        g   = -1;
        cur = eg[cyc];
        if (!go) return;
        if (owner >= 0) begin
            if (pend[owner] && lockw[owner] && burst < MAX_BURST) begin
                g = owner;
                burst++;
                return;
            end
            ptr   = (owner + 1) % NREQ;
            burst = 0;
            owner = -1;
        end
        for (int i = 0; i < NREQ; i++) begin
            int idx = (ptr + i) % NREQ;
            if (g < 0 && pend[idx] && idx != cur) g = idx;
        end
        if (g >= 0) begin
            ptr = (g + 1) % NREQ;
            if (lockw[g]) begin
                owner = g;
                burst = 1;
            end
        end
    endtask

    task automatic check_cycle();
        int e;
        int r;
        logic [NREQ-1:0] eg_l;
        logic [NREQ-1:0] er;
        bit eb;
        e    = eg[cyc];
        eg_l = '1;
        if (e >= 0) eg_l[e] = 1'b0;
        chk("gnt_l", 32'(gnt_l), 32'(eg_l));
        chk("sub_vld", 32'(sub_vld), 32'((e >= 0) ? 1 : 0));
        if (e >= 0) chk("sub_in", 32'(sub_in), 32'(ed[cyc]));
        r  = (cyc - 1 - SUB_LAT >= 0) ? eg[cyc-1-SUB_LAT] : -1;
        er = '0;
        if (r >= 0) begin
            er[r]  = 1'b1;
            exp_rd = sub_fn(ed[cyc-1-SUB_LAT]);
        end
        chk("rsp_vld", 32'(rsp_vld), 32'(er));
        chk("rsp_data", 32'(rsp_data), 32'(exp_rd));
        eb = 1'b0;
        for (int j = cyc - SUB_LAT - 1; j <= cyc; j++)
            if (j >= 0 && eg[j] >= 0) eb = 1'b1;
        chk("busy", 32'(busy), 32'(eb));
    endtask

    task automatic tick(input bit rel);
        bit en;
        bit rdy;
        int g;
        @(posedge clk);
        cyc++;
        #1;
        en = last_rst_high;
        if (rel) reset_l = 1'b1;
        for (int i = 0; i < NREQ; i++) begin
            if (eg[cyc-1] == i && !hold[i]) begin
                if (rand_mode && lockw[i] && $urandom_range(0, 1) == 1) data[i] = DW'($urandom);
                else pend[i] = 1'b0;
            end
            if (rand_mode && pend[i] && lockw[i] && $urandom_range(0, 7) == 0) lockw[i] = 1'b0;
            if (rand_mode && !pend[i] && $urandom_range(0, 9) < 3) begin
                pend[i]  = 1'b1;
                data[i]  = DW'($urandom);
                lockw[i] = ($urandom_range(0, 3) == 0);
            end
        end
        rdy = rand_mode ? ($urandom_range(0, 99) < 85) : rdy_dir;
        for (int i = 0; i < NREQ; i++) begin
            req_l[i]  = ~pend[i];
            lock_l[i] = ~lockw[i];
            req_data[i*DW +: DW] = data[i];
        end
        sub_rdy = rdy;
        sub_out = (cyc >= SUB_LAT && eg[cyc-SUB_LAT] >= 0) ? sub_fn(ed[cyc-SUB_LAT]) : DW'($urandom);
        model_decide(en && reset_l && rdy, g);
        eg[cyc+1] = g;
        ed[cyc+1] = (g >= 0) ? data[g] : '0;
        last_rst_high = reset_l;
        @(negedge clk);
        check_cycle();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick(1'b0);
    endtask

    task automatic check_reset_values();
        chk("rst_gnt_l", 32'(gnt_l), 32'({NREQ{1'b1}}));
        chk("rst_sub_vld", 32'(sub_vld), 32'(0));
        chk("rst_sub_in", 32'(sub_in), 32'(0));
        chk("rst_rsp_vld", 32'(rsp_vld), 32'(0));
        chk("rst_rsp_data", 32'(rsp_data), 32'(0));
        chk("rst_busy", 32'(busy), 32'(0));
    endtask

    // Assert reset mid-cycle, check outputs immediately, flush the reference.
    task automatic rst_pulse();
        @(posedge clk);
        cyc++;
        #1;
        reset_l = 1'b0;
        for (int j = cyc - SUB_LAT - 1; j <= cyc + 1; j++)
            if (j >= 0) eg[j] = -1;
        ptr = 0; owner = -1; burst = 0;
        exp_rd = '0;
        last_rst_high = 1'b0;
        #1;
        check_reset_values();
        @(negedge clk);
        check_cycle();
    endtask

    task automatic quiesce();
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 1'b0; lockw[i] = 1'b0; hold[i] = 1'b0;
        end
        run(6);
    endtask

    initial begin
        for (int j = 0; j < MAXC; j++) begin eg[j] = -1; ed[j] = '0; end
        for (int i = 0; i < NREQ; i++) begin
            pend[i] = 1'b0; lockw[i] = 1'b0; hold[i] = 1'b0; data[i] = '0;
        end
        reset_l  = 1'b1;
        req_l    = '1;
        lock_l   = '1;
        req_data = '0;
        sub_rdy  = 1'b1;
        sub_out  = '0;
        #1 reset_l = 1'b0;
        #1 check_reset_values();
        run(2);

        // Single request from requester 2, present through the reset release.
        pend[2] = 1'b1; data[2] = 3'h5;
        tick(1'b1);
        run(8);

        // All four request together: one grant each, round-robin order.
        for (int i = 0; i < NREQ; i++) begin pend[i] = 1'b1; data[i] = DW'($urandom); end
        run(10);
        quiesce();

        // Pointer at 3 then 2, with requesters 1 and 2 competing.
        pend[2] = 1'b1; data[2] = 3'h3; run(6);
        pend[1] = 1'b1; pend[2] = 1'b1; data[1] = 3'h1; data[2] = 3'h2; run(8);
        pend[1] = 1'b1; data[1] = 3'h7; run(6);
        pend[1] = 1'b1; pend[2] = 1'b1; data[1] = 3'h4; data[2] = 3'h6; run(8);
        quiesce();

        // Locked burst: requester 0 locked and held, requester 1 held.
        hold[0] = 1'b1; hold[1] = 1'b1; pend[0] = 1'b1; pend[1] = 1'b1;
        lockw[0] = 1'b1; data[0] = 3'h2; data[1] = 3'h5;
        run(8);
        quiesce();

        // Backpressure from the shared unit with requests pending.
        for (int i = 0; i < NREQ; i++) begin pend[i] = 1'b1; data[i] = DW'($urandom); end
        run(2);
        rdy_dir = 1'b0; run(3);
        rdy_dir = 1'b1; run(8);
        quiesce();

        // Reset with operations in flight; lowest index wins afterwards.
        pend[1] = 1'b1; pend[3] = 1'b1; data[1] = 3'h6; data[3] = 3'h1;
        run(3);
        rst_pulse();
        pend[2] = 1'b1; pend[3] = 1'b1; data[2] = 3'h3;
        run(2);
        tick(1'b1);
        run(8);
        quiesce();

        // Random traffic with random locks and backpressure.
        rand_mode = 1'b1;
        run(400);
        rand_mode = 1'b0;
        quiesce();
        run(6);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
